// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: receive-side word handshake between the UART receiver and its consumer.
// Signals: rx_data (received word, LSB first on line), rx_valid (word pending),
//          rx_ready (consumer accepts when valid & ready), parity_err, frame_err (flags for rx_data).
// Modports: master = receiver (drives word and flags), slave = consumer (drives rx_ready).
interface uart_rx_core_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    modport master (output rx_data, rx_valid, parity_err, frame_err, input rx_ready);
    modport slave  (input rx_data, rx_valid, parity_err, frame_err, output rx_ready);
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with majority-vote bit sampling and valid/ready output.
// Ports: clk (system clock), rst_n (async active-low reset), uart_rx (async serial line, idle high),
//        rx (uart_rx_core_if.master: rx_data/rx_valid/rx_ready/parity_err/frame_err),
//        overrun (1-cycle pulse when a completed word is dropped), busy (receiver not idle).
module uart_rx_core #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           uart_rx,
    uart_rx_core_if.master rx,
    output logic           overrun,
    output logic           busy
);
    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [TW-1:0] T_S0     = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1     = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_VOTE   = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(DATA_BITS - 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;

    logic                 sync1, sync2, line_q;
    logic [2:0]           state;
    logic [DW-1:0]        div_cnt;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic                 smp0, smp1;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr, ferr, done;
    logic                 tick, vote, maj, ferr_new, par_x;

    assign tick     = div_cnt == DIV_LAST;
    // All state changes happen at the mid-bit vote; the tick counter keeps
    // free-running across bits, so the next vote lands one bit period later.
    assign vote     = tick && tick_cnt == T_VOTE;
    assign maj      = (smp0 & smp1) | (smp0 & sync2) | (smp1 & sync2);
    assign ferr_new = ferr | ~maj;
    assign par_x    = ^shreg ^ maj;
    assign busy     = state != S_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            line_q   <= 1'b1;
            state    <= S_IDLE;
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            smp0     <= 1'b0;
            smp1     <= 1'b0;
            shreg    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            done     <= 1'b0;
        end else begin
            sync1 <= uart_rx;
            sync2 <= sync1;
            line_q <= sync2;
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (line_q && !sync2) begin
                    state    <= S_START;
                    div_cnt  <= '0;
                    tick_cnt <= '0;
                end
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) tick_cnt <= tick_cnt == T_LAST ? '0 : tick_cnt + 1'b1;
                if (tick && tick_cnt == T_S0) smp0 <= sync2;
                if (tick && tick_cnt == T_S1) smp1 <= sync2;
                if (vote) begin
                    case (state)
                        S_START: begin
                            state    <= maj ? S_IDLE : S_DATA;
                            bit_cnt  <= '0;
                            stop_cnt <= 1'b0;
                            perr     <= 1'b0;
                            ferr     <= 1'b0;
                        end
                        S_DATA: begin
                            shreg   <= {maj, shreg[DATA_BITS-1:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == B_LAST) state <= PARITY == 0 ? S_STOP : S_PAR;
                        end
                        S_PAR: begin
                            perr  <= PARITY == 1 ? ~par_x : par_x;
                            state <= S_STOP;
                        end
                        S_STOP: begin
                            ferr     <= ferr_new;
                            stop_cnt <= 1'b1;
                            if (stop_cnt == 1'(STOP_BITS - 1)) begin
                                done  <= 1'b1;
                                state <= ferr_new ? S_WAIT : S_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
                if (state == S_WAIT && sync2) state <= S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx.rx_data    <= '0;
            rx.rx_valid   <= 1'b0;
            rx.parity_err <= 1'b0;
            rx.frame_err  <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            overrun <= done && rx.rx_valid && !rx.rx_ready;
            if (done && (!rx.rx_valid || rx.rx_ready)) begin
                rx.rx_data    <= shreg;
                rx.parity_err <= perr;
                rx.frame_err  <= ferr;
                rx.rx_valid   <= 1'b1;
            end else if (rx.rx_ready) begin
                rx.rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed bench for uart_rx_core in three configurations
// (default 8N1 at 864 clk/bit, 7-bit even parity and 8-bit two-stop at 64 clk/bit).
module tb_uart_rx_core;
    localparam int BIT0 = 864;
    localparam int BIT1 = 64;

    logic clk = 1'b0;
    logic rst_n;
    logic line0, line1, line2;
    logic ovr0, ovr1, ovr2, busy0, busy1, busy2;
    int   checks = 0;
    int   failures = 0;
    int   acc0 = 0, acc1 = 0, acc2 = 0, ovc0 = 0, bcnt0 = 0;
    logic [8:0] dat0, dat1, dat2;
    logic pe0, fe0, pe1, fe1, pe2, fe2;
    int   a, b;

    always #5 clk = ~clk;

    uart_rx_core_if #(.DATA_BITS(8)) if0 ();
    uart_rx_core_if #(.DATA_BITS(7)) if1 ();
    uart_rx_core_if #(.DATA_BITS(8)) if2 ();

    uart_rx_core u0 (.clk(clk), .rst_n(rst_n), .uart_rx(line0), .rx(if0), .overrun(ovr0), .busy(busy0));
    uart_rx_core #(.CLK_FREQ(7_372_800), .DATA_BITS(7), .PARITY(2)) u1 (
        .clk(clk), .rst_n(rst_n), .uart_rx(line1), .rx(if1), .overrun(ovr1), .busy(busy1));
    uart_rx_core #(.CLK_FREQ(7_372_800), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .uart_rx(line2), .rx(if2), .overrun(ovr2), .busy(busy2));

    always @(negedge clk) begin
        if (if0.rx_valid && if0.rx_ready) begin
            acc0++;
            dat0 = 9'(if0.rx_data);
            pe0 = if0.parity_err;
            fe0 = if0.frame_err;
        end
        if (if1.rx_valid && if1.rx_ready) begin
            acc1++;
            dat1 = 9'(if1.rx_data);
            pe1 = if1.parity_err;
            fe1 = if1.frame_err;
        end
        if (if2.rx_valid && if2.rx_ready) begin
            acc2++;
            dat2 = 9'(if2.rx_data);
            pe2 = if2.parity_err;
            fe2 = if2.frame_err;
        end
        if (ovr0) ovc0++;
        if (busy0) bcnt0++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input int ln, input logic v);
        if (ln == 0) line0 = v;
        else if (ln == 1) line1 = v;
        else line2 = v;
    endtask

    task automatic send(input int ln, input logic [15:0] bits, input int n, input int cpb);
        for (int i = 0; i < n; i++) begin
            set_line(ln, bits[i]);
            repeat (cpb) @(negedge clk);
        end
        set_line(ln, 1'b1);
    endtask

    task automatic send_keep(input int ln, input logic [15:0] bits, input int n, input int cpb);
        for (int i = 0; i < n; i++) begin
            set_line(ln, bits[i]);
            repeat (cpb) @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        line0 = 1'b1;
        line1 = 1'b1;
        line2 = 1'b1;
        if0.rx_ready = 1'b1;
        if1.rx_ready = 1'b1;
        if2.rx_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_valid", 32'(if0.rx_valid), 0);
        chk("rst_data", 32'(if0.rx_data), 0);
        chk("rst_flags", 32'({if0.parity_err, if0.frame_err}), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_overrun", 32'(ovr0), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        a = acc0;
        send(0, 16'({1'b1, 8'hA5, 1'b0}), 10, BIT0);
        repeat (100) @(negedge clk);
        chk("a5_count", 32'(acc0 - a), 1);
        chk("a5_data", 32'(dat0), 32'hA5);
        chk("a5_perr", 32'(pe0), 0);
        chk("a5_ferr", 32'(fe0), 0);
        a = acc0;
        b = bcnt0;
        line0 = 1'b0;
        repeat (200) @(negedge clk);
        line0 = 1'b1;
        repeat (1500) @(negedge clk);
        chk("glitch_busy_seen", 32'(bcnt0 - b != 0), 1);
        chk("glitch_no_valid", 32'(acc0 - a), 0);
        chk("glitch_idle", 32'(busy0), 0);
        a = acc0;
        send_keep(0, 16'({1'b0, 8'h3C, 1'b0}), 10, BIT0);
        repeat (1000) @(negedge clk);
        chk("fe_wait_busy", 32'(busy0), 1);
        repeat (1000) @(negedge clk);
        line0 = 1'b1;
        repeat (100) @(negedge clk);
        chk("fe_count", 32'(acc0 - a), 1);
        chk("fe_data", 32'(dat0), 32'h3C);
        chk("fe_ferr", 32'(fe0), 1);
        chk("fe_perr", 32'(pe0), 0);
        chk("fe_idle", 32'(busy0), 0);
        a = acc0;
        send(0, 16'({1'b1, 8'h11, 1'b0}), 10, BIT0);
        repeat (100) @(negedge clk);
        chk("after_fe_count", 32'(acc0 - a), 1);
        chk("after_fe_data", 32'(dat0), 32'h11);
        chk("after_fe_ferr", 32'(fe0), 0);
        if0.rx_ready = 1'b0;
        b = ovc0;
        send(0, 16'({1'b1, 8'h01, 1'b0}), 10, BIT0);
        send(0, 16'({1'b1, 8'h02, 1'b0}), 10, BIT0);
        repeat (100) @(negedge clk);
        chk("ovr_valid", 32'(if0.rx_valid), 1);
        chk("ovr_data_kept", 32'(if0.rx_data), 32'h01);
        chk("ovr_pulse_cycles", 32'(ovc0 - b), 1);
        if0.rx_ready = 1'b1;
        @(negedge clk);
        chk("ovr_accepted", 32'(if0.rx_valid), 0);
        a = acc1;
        send(1, 16'({1'b1, 1'b1, 7'h35, 1'b0}), 10, BIT1);
        repeat (50) @(negedge clk);
        chk("par_bad_count", 32'(acc1 - a), 1);
        chk("par_bad_data", 32'(dat1), 32'h35);
        chk("par_bad_perr", 32'(pe1), 1);
        chk("par_bad_ferr", 32'(fe1), 0);
        send(1, 16'({1'b1, 1'b0, 7'h35, 1'b0}), 10, BIT1);
        repeat (50) @(negedge clk);
        chk("par_ok_count", 32'(acc1 - a), 2);
        chk("par_ok_perr", 32'(pe1), 0);
        a = acc2;
        send(2, 16'({1'b0, 1'b1, 8'h5C, 1'b0}), 11, BIT1);
        repeat (50) @(negedge clk);
        chk("stop2_bad_count", 32'(acc2 - a), 1);
        chk("stop2_bad_data", 32'(dat2), 32'h5C);
        chk("stop2_bad_ferr", 32'(fe2), 1);
        send(2, 16'({1'b1, 1'b1, 8'hC3, 1'b0}), 11, BIT1);
        repeat (50) @(negedge clk);
        chk("stop2_ok_data", 32'(dat2), 32'hC3);
        chk("stop2_ok_ferr", 32'(fe2), 0);
        a = acc0;
        send_keep(0, 16'({4'h6, 1'b0}), 5, BIT0);
        line0 = 1'b1;
        repeat (400) @(negedge clk);
        chk("mid_frame_busy", 32'(busy0), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(if0.rx_valid), 0);
        chk("mid_rst_data", 32'(if0.rx_data), 0);
        chk("mid_rst_busy", 32'(busy0), 0);
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        repeat (5000) @(negedge clk);
        chk("post_rst_no_word", 32'(acc0 - a), 0);
        send(0, 16'({1'b1, 8'h5A, 1'b0}), 10, BIT0);
        repeat (100) @(negedge clk);
        chk("post_rst_count", 32'(acc0 - a), 1);
        chk("post_rst_data", 32'(dat0), 32'h5A);
        chk("post_rst_flags", 32'({pe0, fe0}), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, line bit rate in bit/s.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, default 1, stop bits checked, legal values 1 or 2.
REQ-006 Parameter OVERSAMPLE, default 16, sample ticks per bit, even, at least 8.
REQ-007 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-008 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-009 Port uart_rx  input  1  asynchronous serial line, idle high.
REQ-010 Port rx_data  output  DATA_BITS  received word, LSB = first data bit on the line.
REQ-011 Port rx_valid  output  1  rx_data and flags hold a word not yet accepted.
REQ-012 Port rx_ready  input  1  consumer accepts the word in any cycle where rx_valid and rx_ready are both 1.
REQ-013 Port parity_err  output  1  parity mismatch for the word in rx_data; valid while rx_valid is 1.
REQ-014 Port frame_err  output  1  a stop bit was sampled 0 for the word in rx_data; valid while rx_valid is 1.
REQ-015 Port overrun  output  1  one-cycle pulse when a completed frame is dropped.
REQ-016 Port busy  output  1  high whenever the state machine is not in IDLE.

Function
REQ-017 uart_rx SHALL pass through a 2-flop synchronizer whose flops reset to 1; all logic uses the synchronized value.
REQ-018 A tick SHALL be generated every DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks, using integer truncation; the divider SHALL restart at the start-edge detect.
REQ-019 States SHALL be IDLE, START, DATA, PARITY, STOP, and WAIT_IDLE; PARITY is skipped when PARITY = 0.
REQ-020 IDLE->START SHALL occur on a 1->0 transition of the synchronized line.
REQ-021 Each bit value SHALL be the majority of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit.
REQ-022 START: if the majority vote is 1, the start is false; return to IDLE with no output change; otherwise go to DATA.
REQ-023 DATA SHALL shift in DATA_BITS bits LSB first, then go to PARITY or STOP.
REQ-024 PARITY: error SHALL be set when the XOR of the data bits and the parity bit is 0 for odd mode or 1 for even mode.
REQ-025 STOP SHALL check STOP_BITS stop bits; any stop bit voted 0 sets frame_err.
REQ-026 The frame SHALL complete at the mid-bit vote of the last stop bit; the state then returns to IDLE without waiting for the end of the bit.
REQ-027 If frame_err is set, the state SHALL enter WAIT_IDLE and leave it only when the synchronized line reads 1.
REQ-028 On frame completion, words with errors SHALL still be delivered: rx_data, parity_err, frame_err and rx_valid are loaded in the next cycle.
REQ-029 rx_valid SHALL stay high, with rx_data and flags stable, until accepted by rx_ready.
REQ-030 If a frame completes while rx_valid=1 and rx_ready=0: the new word is dropped, the old word is kept, and overrun pulses for 1 cycle.
REQ-031 If a frame completes in the same cycle as an acceptance: the new word loads, rx_valid stays 1, and there is no overrun.
REQ-032 Line activity SHALL NOT be blocked by a pending output; reception continues while rx_valid is 1.

Reset
REQ-033 While rst_n=0: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, state=IDLE, all counters 0, synchronizer flops=1.
REQ-034 Reset asserted mid-frame SHALL abort the frame immediately, with no output generated.
REQ-035 After release, the first frame SHALL be recognized only from a fresh 1->0 edge.

Verification
REQ-036 Defaults (DIV=54, 864 clk/bit); send 0xA5 8N1 with rx_ready=1 -> one rx_valid pulse, rx_data=0xA5, both error flags 0.
REQ-037 PARITY=2, DATA_BITS=7; send 0x35 with wrong parity bit -> rx_data=0x35, parity_err=1, frame_err=0.
REQ-038 Drive a 200-clk low glitch on idle line -> busy pulses, rx_valid stays 0.
REQ-039 Send 0x3C with stop bit 0, then hold the line low for 2000 clk, then high -> frame_err=1, rx_data=0x3C; the next frame 0x11 is received correctly.
REQ-040 Hold rx_ready=0 and send 0x01 then 0x02 -> rx_data=0x01 stays, one overrun pulse; with STOP_BITS=2, a second stop bit of 0 sets frame_err.
REQ-041 Assert rst_n=0 at data bit 4 of a frame -> all outputs 0; after release, the next full frame 0x5A is received correctly.
